rvh_l1d_stb_coalesce: RTL and testbench

- Store coalescing buffer between the store mask/data translation stage and the L1D store port.
- Accepts line-aligned stores (512-bit data plus 64-bit byte mask plus line address). Stores to the same line merge into one entry.
- Drains whole-line, mask-qualified writes to the L1D in allocation (FIFO) order.
- Gives the Ruby/LSU side a single-cycle-accept store path and cuts L1D write traffic.

---
 rtl/rvh_l1d_stb_coalesce.sv | 149 ++++++++++++++
 tb/tb_rvh_l1d_stb_coalesce.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rvh_l1d_stb_coalesce.sv
// Store coalescing buffer: merges line-aligned stores to the same line and drains
// whole-line, byte-masked writes to the L1D in allocation order.
module rvh_l1d_stb_coalesce #(
    parameter int unsigned ENTRY_NUM   = 4,
    parameter int unsigned LINE_ADDR_W = 50,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   st_req_vld_i,
    output logic                   st_req_rdy_o,
    input  logic [LINE_ADDR_W-1:0] st_req_line_addr_i,
    input  logic [511:0]           st_req_data_i,
    input  logic [63:0]            st_req_mask_i,
    input  logic                   flush_i,
    output logic                   l1d_st_vld_o,
    input  logic                   l1d_st_rdy_i,
    output logic [LINE_ADDR_W-1:0] l1d_st_line_addr_o,
    output logic [511:0]           l1d_st_data_o,
    output logic [63:0]            l1d_st_mask_o,
    output logic                   empty_o,
    output logic                   full_o
);
    localparam int unsigned PTR_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;
    localparam int unsigned CNT_W = $clog2(ENTRY_NUM + 1);
    localparam int unsigned AGE_W = $clog2(TIMEOUT + 1);

    logic [ENTRY_NUM-1:0]   valid_q;
    logic [LINE_ADDR_W-1:0] addr_q [ENTRY_NUM];
    logic [511:0]           data_q [ENTRY_NUM];
    logic [63:0]            mask_q [ENTRY_NUM];
    logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [AGE_W-1:0]       age_q, age_d;
    logic                   lock_q, lock_d;

    logic                   head_vld, drain_vld, drain_hs;
    logic [ENTRY_NUM-1:0]   match;
    logic                   hit;
    logic [PTR_W-1:0]       hit_idx;
    logic                   acc, do_alloc, do_merge, merge_head;
    logic [511:0]           byte_bits;

    assign head_vld  = valid_q[head_q];
    assign drain_vld = head_vld && ((count_q == CNT_W'(ENTRY_NUM)) || flush_i ||
                                    (age_q >= AGE_W'(TIMEOUT)) || lock_q);
    assign drain_hs  = drain_vld && l1d_st_rdy_i;

    // The presented head is frozen, so it never counts as a merge target.
    for (genvar gi = 0; gi < ENTRY_NUM; gi++) begin : g_match
        assign match[gi] = valid_q[gi] && (addr_q[gi] == st_req_line_addr_i) &&
                           !(drain_vld && (head_q == PTR_W'(gi)));
    end

    for (genvar gi = 0; gi < 64; gi++) begin : g_bytes
        assign byte_bits[8*gi +: 8] = {8{st_req_mask_i[gi]}};
    end

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = head_q;
        for (int k = 0; k < ENTRY_NUM; k++) begin
            if (match[head_q + PTR_W'(k)]) begin
                hit     = 1'b1;
                hit_idx = head_q + PTR_W'(k);
            end
        end
    end

    assign st_req_rdy_o = hit || (count_q < CNT_W'(ENTRY_NUM));
    assign acc          = st_req_vld_i && st_req_rdy_o;
    assign do_merge     = acc && hit;
    assign do_alloc     = acc && !hit;
    assign merge_head   = do_merge && (hit_idx == head_q);

    always_comb begin
        head_d  = head_q + PTR_W'(drain_hs);
        tail_d  = tail_q + PTR_W'(do_alloc);
        count_d = count_q + CNT_W'(do_alloc) - CNT_W'(drain_hs);
        lock_d  = lock_q;
        if (drain_hs)
            lock_d = 1'b0;
        else if (drain_vld)
            lock_d = 1'b1;
        age_d = age_q;
        if ((count_d == '0) || drain_hs || merge_head)
            age_d = '0;
        else if (head_vld && (age_q < AGE_W'(TIMEOUT)))
            age_d = age_q + AGE_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            age_q   <= '0;
            lock_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            age_q   <= age_d;
            lock_q  <= lock_d;
        end
    end

    for (genvar gi = 0; gi < ENTRY_NUM; gi++) begin : g_entry
        logic we_alloc, we_merge, clr;
        assign we_alloc = do_alloc && (tail_q == PTR_W'(gi));
        assign we_merge = do_merge && (hit_idx == PTR_W'(gi));
        assign clr      = drain_hs && (head_q == PTR_W'(gi));

        always_ff @(posedge clk) begin
            if (!rst) begin
                valid_q[gi] <= 1'b0;
                mask_q[gi]  <= '0;
            end else begin
                if (clr)
                    valid_q[gi] <= 1'b0;
                if (we_alloc) begin
                    valid_q[gi] <= 1'b1;
                    mask_q[gi]  <= st_req_mask_i;
                end else if (we_merge) begin
                    mask_q[gi]  <= mask_q[gi] | st_req_mask_i;
                end
            end
        end

        // Payload needs no reset: bytes are only meaningful under their mask bit.
        always_ff @(posedge clk) begin
            if (we_alloc) begin
                addr_q[gi] <= st_req_line_addr_i;
                data_q[gi] <= st_req_data_i;
            end else if (we_merge) begin
                data_q[gi] <= (data_q[gi] & ~byte_bits) | (st_req_data_i & byte_bits);
            end
        end
    end

    assign l1d_st_vld_o       = drain_vld;
    assign l1d_st_line_addr_o = addr_q[head_q];
    assign l1d_st_data_o      = data_q[head_q];
    assign l1d_st_mask_o      = mask_q[head_q];
    assign empty_o            = (count_q == '0);
    assign full_o             = (count_q == CNT_W'(ENTRY_NUM));

endmodule

// File: tb/tb_rvh_l1d_stb_coalesce.sv
// Directed bench for the store coalescing buffer; expected drains are queued when
// stores are driven and compared at each drain handshake.
module tb_rvh_l1d_stb_coalesce;
    localparam int AW = 50;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          st_vld = 1'b0;
    logic          st_rdy;
    logic [AW-1:0] st_addr = '0;
    logic [511:0]  st_data = '0;
    logic [63:0]   st_mask = '0;
    logic          flush = 1'b0;
    logic          l1d_vld;
    logic          l1d_rdy = 1'b0;
    logic [AW-1:0] l1d_addr;
    logic [511:0]  l1d_data;
    logic [63:0]   l1d_mask;
    logic          empty, full;

    typedef struct {
        logic [AW-1:0] addr;
        logic [511:0]  data;
        logic [63:0]   mask;
    } ent_t;

    ent_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    rvh_l1d_stb_coalesce #(.ENTRY_NUM(4), .LINE_ADDR_W(AW), .TIMEOUT(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .st_req_vld_i      (st_vld),
        .st_req_rdy_o      (st_rdy),
        .st_req_line_addr_i(st_addr),
        .st_req_data_i     (st_data),
        .st_req_mask_i     (st_mask),
        .flush_i           (flush),
        .l1d_st_vld_o      (l1d_vld),
        .l1d_st_rdy_i      (l1d_rdy),
        .l1d_st_line_addr_o(l1d_addr),
        .l1d_st_data_o     (l1d_data),
        .l1d_st_mask_o     (l1d_mask),
        .empty_o           (empty),
        .full_o            (full)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] expand(input logic [63:0] m);
        logic [511:0] r;
        for (int i = 0; i < 64; i++) r[8*i +: 8] = {8{m[i]}};
        return r;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one store for a cycle; merge_idx < 0 means a fresh allocation.
    task automatic send(input logic [AW-1:0] a, input logic [511:0] d, input logic [63:0] m,
                        input logic exp_rdy, input int merge_idx, input string tag);
        ent_t t;
        st_vld = 1'b1; st_addr = a; st_data = d; st_mask = m;
        @(negedge clk);
        chk1({tag, "_rdy"}, st_rdy, exp_rdy);
        if (exp_rdy) begin
            if (merge_idx < 0) begin
                t.addr = a; t.data = d; t.mask = m;
                sb.push_back(t);
            end else begin
                t = sb[merge_idx];
                for (int i = 0; i < 64; i++) if (m[i]) t.data[8*i +: 8] = d[8*i +: 8];
                t.mask = t.mask | m;
                sb[merge_idx] = t;
            end
        end
        $display("store %s addr=%0h mask=%0h rdy=%b", tag, a, m, st_rdy);
        @(posedge clk); #1;
        st_vld = 1'b0;
    endtask

    task automatic wait_empty(input int budget, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (empty) seen = 1'b1;
        end
        chk1(tag, seen, 1'b1);
    endtask

    // Scoreboard side: every handshake pops the oldest expected line.
    always @(negedge clk) begin
        ent_t e;
        if (rst && l1d_vld && l1d_rdy) begin
            chk1("drain_expected", sb.size() > 0, 1'b1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chkw("drain_addr", 512'(l1d_addr), 512'(e.addr));
                chkw("drain_mask", 512'(l1d_mask), 512'(e.mask));
                chkw("drain_data", l1d_data & expand(e.mask), e.data & expand(e.mask));
                $display("drain addr=%0h mask=%0h", l1d_addr, l1d_mask);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk1("idle_vld", l1d_vld, 1'b0);
            chk1("idle_empty", empty, 1'b1);
            chk1("idle_rdy", st_rdy, 1'b1);
            chk1("idle_full", full, 1'b0);
        end
        @(posedge clk); #1;

        // Merge then timeout drain
        l1d_rdy = 1'b1;
        send(50'h10, 512'hAA, 64'h1, 1'b1, -1, "to_a");
        send(50'h10, 512'hBB00, 64'h2, 1'b1, 0, "to_b");
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk1("timeout_early_vld", l1d_vld, 1'b0);
        end
        @(negedge clk);
        chk1("timeout_vld", l1d_vld, 1'b1);
        chkw("timeout_mask", 512'(l1d_mask), 512'h3);
        chkw("timeout_bytes", 512'(l1d_data[15:0]), 512'hBBAA);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("timeout_empty", empty, 1'b1);
        @(posedge clk); #1;

        // Overlapping merge, drained by flush
        send(50'h20, 512'h11223344, 64'hF, 1'b1, -1, "ov_a");
        send(50'h20, 512'h55, 64'h1, 1'b1, 0, "ov_b");
        flush = 1'b1;
        @(negedge clk);
        chk1("ov_vld", l1d_vld, 1'b1);
        chkw("ov_word", 512'(l1d_data[31:0]), 512'h11223355);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk1("ov_empty", empty, 1'b1);
        @(posedge clk); #1;

        // Full, forced drain and back-pressure
        l1d_rdy = 1'b0;
        for (int i = 1; i <= 4; i++)
            send(AW'(i), {64{8'(i)}}, 64'hFF, 1'b1, -1, "fill");
        @(negedge clk);
        chk1("full_flag", full, 1'b1);
        chk1("full_vld", l1d_vld, 1'b1);
        chkw("full_head", 512'(l1d_addr), 512'h1);
        @(posedge clk); #1;
        send(50'h5, {64{8'h55}}, 64'hFF, 1'b0, -1, "miss_full");
        send(50'h3, 512'h77 << 64, 64'h100, 1'b1, 2, "merge_full");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("stall_vld", l1d_vld, 1'b1);
            chkw("stall_addr", 512'(l1d_addr), 512'h1);
            chkw("stall_mask", 512'(l1d_mask), 512'(sb[0].mask));
            chkw("stall_data", l1d_data & expand(sb[0].mask), sb[0].data & expand(sb[0].mask));
        end
        @(posedge clk); #1;
        send(50'h1, {64{8'hEE}}, 64'hFF, 1'b0, -1, "locked_head");
        l1d_rdy = 1'b1;
        flush   = 1'b1;
        wait_empty(20, "bp_drain_done");
        @(posedge clk); #1;
        flush = 1'b0;
        chk1("bp_sb_drained", sb.size() == 0, 1'b1);

        // Flush with simultaneous accept
        l1d_rdy = 1'b0;
        for (int i = 1; i <= 3; i++)
            send(AW'(i), {64{8'(i + 16)}}, 64'hFFFF, 1'b1, -1, "fl_fill");
        flush = 1'b1; l1d_rdy = 1'b1;
        st_vld = 1'b1; st_addr = 50'h9; st_data = {64{8'h99}}; st_mask = '1;
        @(negedge clk);
        chk1("fl_accept_rdy", st_rdy, 1'b1);
        begin
            ent_t t;
            t.addr = 50'h9; t.data = {64{8'h99}}; t.mask = '1;
            sb.push_back(t);
        end
        chk1("fl_vld_c0", l1d_vld, 1'b1);
        @(posedge clk); #1;
        st_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("fl_vld_consec", l1d_vld, 1'b1);
        end
        @(negedge clk);
        chk1("fl_empty", empty, 1'b1);
        chk1("fl_vld_off", l1d_vld, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk1("fl_sb_drained", sb.size() == 0, 1'b1);

        // Reset while a drain is stalled
        l1d_rdy = 1'b0;
        for (int i = 1; i <= 4; i++)
            send(AW'(i + 32), {64{8'(i)}}, 64'h1, 1'b1, -1, "rs_fill");
        @(negedge clk);
        chk1("rs_pre_vld", l1d_vld, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk1("rs_vld", l1d_vld, 1'b0);
        chk1("rs_empty", empty, 1'b1);
        chk1("rs_full", full, 1'b0);
        chk1("rs_rdy", st_rdy, 1'b1);
        @(posedge clk); #1;
        send(50'h7, 512'hC3, 64'h1, 1'b1, -1, "rs_after");
        flush = 1'b1; l1d_rdy = 1'b1;
        @(negedge clk);
        chk1("rs_after_vld", l1d_vld, 1'b1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk1("rs_after_empty", empty, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
